issue_scoreboard_ctrl: RTL
==========================

// Module: issue_scoreboard_ctrl
// PURPOSE
//  Issue controller for the dual-issue ID stage; sits between the ID pair and EX.
//  Tracks GPRs whose producer is long-latency (load, div, csr_rw/xchg), because those
//  values cannot be forwarded from EX/MEM. Combines this with the forwarding unit's per-line
//  ready flags to decide, each cycle, whether to issue 0, 1 (line1 only) or 2 instructions, in order.
// PARAMETERS
//  REG_NUM   32  number of GPRs tracked (r0 never tracked)
//  ADDR_W    5   GPR address width
//  CNT_W     2   per-register pending-writer counter width (saturates at 2^CNT_W-1)
// PORTS
//  clk              in   1       clock
//  rst              in   1       synchronous, active-high reset
//  flush_i          in   1       pipeline flush (exception/ertn/branch mispredict)
//  l1_valid_i       in   1       ID line1 holds an instruction
//  l2_valid_i       in   1       ID line2 holds an instruction
//  lN_re1_i/re2_i   in   1 each  lN (N=1,2) source-1/2 read enable
//  lN_raddr1_i/2_i  in   ADDR_W  lN source addresses
//  lN_we_i          in   1       lN writes a GPR
//  lN_waddr_i       in   ADDR_W  lN destination
//  lN_long_i        in   1       lN result is long-latency (not forwardable)
//  lN_div_i         in   1       lN uses the single divider
//  lN_rr_ready_i    in   1       forwarding unit reports lN operands resolvable
//  ex_allow_in_i    in   1       EX accepts a new pair this cycle
//  wbN_release_i    in   1       WB lineN retires a long-latency GPR write
//  wbN_waddr_i      in   ADDR_W  its destination
//  issue_l1_o       out  1       line1 fires into EX this cycle
//  issue_l2_o       out  1       line2 fires into EX this cycle
//  id_allow_in_o    out  1       ID may accept a new pair (1 when ID empty or pair fully issued)
//  id_stall_o       out  1       valid line1 held this cycle
// BEHAVIOUR
//  - Reset (rst=1 at posedge): all counters 0, FSM=RUN. All outputs 0 while rst is high.
//  - Decision is combinational from inputs + registered state; counter update on the next posedge.
//  - busy(r) = cnt[r]!=0, and r!=0.
//  - l1 ok: l1_valid & l1_rr_ready & ex_allow_in & FSM==RUN & no enabled source busy &
//    !(l1_long & l1_we & cnt[l1_waddr]==MAX).
//  - l2 ok: l1 ok & l2_valid & l2_rr_ready & no enabled source busy & same saturation check.
//    Also: no RAW on l1 (l1_we & l1_waddr!=0 & l2 source==l1_waddr) & !(l1_div & l2_div).
//  - issue_l2 never without issue_l1 (in-order). If only l1 issues, l2 stays in ID and is re-presented as line1.
//  - Counters: +1 per issued long writer (waddr!=0), -1 per wb release. Same-cycle inc+dec on
//    one reg nets 0. Both lines long to the same reg in one cycle: +2, saturation checked on the sum.
//  - A release on a reg whose count is 0 is ignored (no underflow); sim-only assertion flags it.
//  - WAW l1/l2 same dest is allowed; ordering is kept by the counter.
//  - FSM: RUN -> FLUSH on flush_i. FLUSH: clear all counters, issue nothing, id_allow_in=1,
//    ignore releases; FLUSH -> RUN after one cycle. flush_i wins over issue/release in the
//    same cycle. flush_i held high keeps FLUSH.
//  - id_stall_o = l1_valid & !issue_l1.
// CONFIGURATION
//  ISSUE_PERF_CNT_EN defined: adds 32-bit outputs perf_stall_o, perf_single_o, perf_dual_o.
//    Each counts (wrapping) cycles with stall / one issued / two issued; reset to 0; not flush-cleared.
//  ISSUE_PERF_CNT_EN undefined: those ports and registers are absent; behaviour otherwise identical.
// STRUCTURE
//  - DefineModuleBus.h gains IssueCtrlIbusWidth / WbReleaseBusWidth, the CNT_MAX constant and
//    the FSM state encodings (RUN=1'b0, FLUSH=1'b1).
//  - One sub-module: scb_counter_bank (REG_NUM x CNT_W counters; two inc ports, two dec ports,
//    clear; busy vector and saturation outputs). Issue logic and FSM live in the top.
// TESTING
//  1 l1 ld r4 (long), then l1 add r5,r4,r0 -> cycle1 issue_l1=1, cnt[4]=1; add stalls
//    (id_stall=1) until wb1_release r4, then issues the following cycle.
//  2 pair l1 add r6,r1,r2 / l2 sub r7,r6,r3 -> issue_l1=1, issue_l2=0; next cycle sub is line1 and issues.
//  3 pair l1 div.w r8 / l2 mod.w r9, both div -> only l1 issues; cnt[8]=1; l2 issues the next cycle.
//  4 four back-to-back long writers to r10 with no release -> cnt reaches 3; 4th held until a release.
//  5 flush_i with cnt[4]=2 and a same-cycle wb release of r4 -> next cycle cnt all 0, no issue;
//    RUN resumes a cycle later.
//  6 rst pulse mid-stall -> all outputs 0, counters 0; with ISSUE_PERF_CNT_EN the perf counters read 0.

Source files
------------

// File: rtl/issue_scoreboard_ctrl_pkg.sv
// Shared types and constants for the dual-issue scoreboard controller:
// line/release bus layouts, counter limit and FSM state encodings.
package issue_scoreboard_ctrl_pkg;

  localparam int REG_NUM = 32;
  localparam int ADDR_W  = 5;
  localparam int CNT_W   = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } issue_state_e;

  typedef struct packed {
    logic              valid;
    logic              re1;
    logic              re2;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic              long_op;
    logic              div_op;
    logic              rr_ready;
  } issue_line_t;

  typedef struct packed {
    logic              release_en;
    logic [ADDR_W-1:0] waddr;
  } wb_release_t;

  localparam int ISSUE_IBUS_W     = $bits(issue_line_t);
  localparam int WB_RELEASE_BUS_W = $bits(wb_release_t);

  function automatic logic src_busy(input issue_line_t ln, input logic [REG_NUM-1:0] busy);
    return (ln.re1 & busy[ln.raddr1]) | (ln.re2 & busy[ln.raddr2]);
  endfunction

  // Consumer reads a register the producer writes in the same pair.
  function automatic logic raw_hit(input issue_line_t prod, input issue_line_t cons);
    logic wr;
    wr = prod.we & (prod.waddr != '0);
    return wr & ((cons.re1 & (cons.raddr1 == prod.waddr)) |
                 (cons.re2 & (cons.raddr2 == prod.waddr)));
  endfunction

endpackage

// File: rtl/issue_scoreboard_ctrl_counter_bank.sv
// Per-GPR pending long-latency writer counters (r0 hard-wired to zero),
// with two increment ports, two decrement ports and a synchronous clear.
module scb_counter_bank #(
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               inc1_en,
  input  logic [ADDR_W-1:0]  inc1_addr,
  input  logic               inc2_en,
  input  logic [ADDR_W-1:0]  inc2_addr,
  input  logic               dec1_en,
  input  logic [ADDR_W-1:0]  dec1_addr,
  input  logic               dec2_en,
  input  logic [ADDR_W-1:0]  dec2_addr,
  output logic [REG_NUM-1:0] busy,
  output logic [REG_NUM-1:0] sat,
  output logic [REG_NUM-1:0] near_sat
);

  localparam logic [CNT_W-1:0] MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MAX_M1 = MAX - 1'b1;

  // Increments land before decrements so a same-cycle inc/dec pair nets zero;
  // excess decrements floor at zero.
  function automatic logic [CNT_W-1:0] next_cnt(input logic [CNT_W-1:0] c,
                                                 input logic [1:0] n_inc,
                                                 input logic [1:0] n_dec);
    logic [CNT_W+1:0] s;
    logic [CNT_W+1:0] d;
    s = {2'b00, c} + {{CNT_W{1'b0}}, n_inc};
    d = {{CNT_W{1'b0}}, n_dec};
    if (d >= s) return '0;
    s = s - d;
    if (s > {2'b00, MAX}) return MAX;
    return s[CNT_W-1:0];
  endfunction

  for (genvar g = 0; g < REG_NUM; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt;

    if (g == 0) begin : g_zero
      assign cnt = '0;
    end else begin : g_live
      logic [1:0] n_inc;
      logic [1:0] n_dec;

      assign n_inc = {1'b0, inc1_en & (inc1_addr == ADDR_W'(g))} +
                     {1'b0, inc2_en & (inc2_addr == ADDR_W'(g))};
      assign n_dec = {1'b0, dec1_en & (dec1_addr == ADDR_W'(g))} +
                     {1'b0, dec2_en & (dec2_addr == ADDR_W'(g))};

      always_ff @(posedge clk) begin
        if (rst || clear) cnt <= '0;
        else              cnt <= next_cnt(cnt, n_inc, n_dec);
      end

      // A release with nothing outstanding means the WB side lost track.
      always_ff @(posedge clk) begin
        if (!rst && !clear && (n_dec != 2'd0)) begin
          assert ({{CNT_W{1'b0}}, n_dec} <= ({2'b00, cnt} + {{CNT_W{1'b0}}, n_inc}));
        end
      end
    end

    assign busy[g]     = (cnt != '0);
    assign sat[g]      = (cnt == MAX);
    assign near_sat[g] = (cnt == MAX_M1);
  end

endmodule

// File: rtl/issue_scoreboard_ctrl.sv
// Dual-issue ID->EX issue controller with long-latency GPR scoreboard.
// Optional perf counters enabled by defining ISSUE_PERF_CNT_EN.
//
// state    | meaning
// ST_RUN   | normal issue, counters track long writers and releases
// ST_FLUSH | counters cleared, nothing issues, ID accepts a new pair
module issue_scoreboard_ctrl
  import issue_scoreboard_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              l1_valid_i,
  input  logic              l2_valid_i,
  input  logic              l1_re1_i,
  input  logic              l1_re2_i,
  input  logic [ADDR_W-1:0] l1_raddr1_i,
  input  logic [ADDR_W-1:0] l1_raddr2_i,
  input  logic              l1_we_i,
  input  logic [ADDR_W-1:0] l1_waddr_i,
  input  logic              l1_long_i,
  input  logic              l1_div_i,
  input  logic              l1_rr_ready_i,
  input  logic              l2_re1_i,
  input  logic              l2_re2_i,
  input  logic [ADDR_W-1:0] l2_raddr1_i,
  input  logic [ADDR_W-1:0] l2_raddr2_i,
  input  logic              l2_we_i,
  input  logic [ADDR_W-1:0] l2_waddr_i,
  input  logic              l2_long_i,
  input  logic              l2_div_i,
  input  logic              l2_rr_ready_i,
  input  logic              ex_allow_in_i,
  input  logic              wb1_release_i,
  input  logic [ADDR_W-1:0] wb1_waddr_i,
  input  logic              wb2_release_i,
  input  logic [ADDR_W-1:0] wb2_waddr_i,
  output logic              issue_l1_o,
  output logic              issue_l2_o,
  output logic              id_allow_in_o,
  output logic              id_stall_o
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_o,
  output logic [31:0]       perf_single_o,
  output logic [31:0]       perf_dual_o
`endif
);

  issue_state_e state;
  issue_line_t  l1;
  issue_line_t  l2;
  wb_release_t  wb1;
  wb_release_t  wb2;

  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] sat;
  logic [REG_NUM-1:0] near_sat;

  logic run_ok;
  logic l1_long_wr;
  logic l2_long_wr;
  logic l1_sat_blk;
  logic l2_sat_blk;
  logic l1_ok;
  logic l2_ok;
  logic rel_ok;
  logic bank_clear;

  assign l1 = '{valid: l1_valid_i, re1: l1_re1_i, re2: l1_re2_i,
                raddr1: l1_raddr1_i, raddr2: l1_raddr2_i, we: l1_we_i,
                waddr: l1_waddr_i, long_op: l1_long_i, div_op: l1_div_i,
                rr_ready: l1_rr_ready_i};
  assign l2 = '{valid: l2_valid_i, re1: l2_re1_i, re2: l2_re2_i,
                raddr1: l2_raddr1_i, raddr2: l2_raddr2_i, we: l2_we_i,
                waddr: l2_waddr_i, long_op: l2_long_i, div_op: l2_div_i,
                rr_ready: l2_rr_ready_i};
  assign wb1 = '{release_en: wb1_release_i, waddr: wb1_waddr_i};
  assign wb2 = '{release_en: wb2_release_i, waddr: wb2_waddr_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:   if (flush_i) state <= ST_FLUSH;
        ST_FLUSH: if (!flush_i) state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

  assign run_ok     = !rst && (state == ST_RUN) && !flush_i;
  assign l1_long_wr = l1.long_op & l1.we;
  assign l2_long_wr = l2.long_op & l2.we;
  assign l1_sat_blk = l1_long_wr & sat[l1.waddr];
  // Two long writers to one register in a pair need room for both.
  assign l2_sat_blk = l2_long_wr & (sat[l2.waddr] |
                      (l1_long_wr & (l1.waddr == l2.waddr) & (l2.waddr != '0) &
                       near_sat[l2.waddr]));

  assign l1_ok = run_ok & l1.valid & l1.rr_ready & ex_allow_in_i &
                 !src_busy(l1, busy) & !l1_sat_blk;
  assign l2_ok = l1_ok & l2.valid & l2.rr_ready & !src_busy(l2, busy) & !l2_sat_blk &
                 !raw_hit(l1, l2) & !(l1.div_op & l2.div_op);

  assign rel_ok     = run_ok;
  assign bank_clear = (state == ST_FLUSH) | flush_i;

  scb_counter_bank #(
    .REG_NUM (REG_NUM),
    .ADDR_W  (ADDR_W),
    .CNT_W   (CNT_W)
  ) u_bank (
    .clk       (clk),
    .rst       (rst),
    .clear     (bank_clear),
    .inc1_en   (l1_ok & l1_long_wr & (l1.waddr != '0)),
    .inc1_addr (l1.waddr),
    .inc2_en   (l2_ok & l2_long_wr & (l2.waddr != '0)),
    .inc2_addr (l2.waddr),
    .dec1_en   (rel_ok & wb1.release_en & (wb1.waddr != '0)),
    .dec1_addr (wb1.waddr),
    .dec2_en   (rel_ok & wb2.release_en & (wb2.waddr != '0)),
    .dec2_addr (wb2.waddr),
    .busy      (busy),
    .sat       (sat),
    .near_sat  (near_sat)
  );

  assign issue_l1_o = l1_ok;
  assign issue_l2_o = l2_ok;
  assign id_stall_o = !rst & l1.valid & !l1_ok;

  always_comb begin
    id_allow_in_o = 1'b0;
    if (!rst) begin
      if (state == ST_FLUSH) id_allow_in_o = 1'b1;
      else id_allow_in_o = !l1.valid | (l1_ok & (!l2.valid | l2_ok));
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_o  <= '0;
      perf_single_o <= '0;
      perf_dual_o   <= '0;
    end else begin
      if (id_stall_o)         perf_stall_o  <= perf_stall_o + 32'd1;
      if (l1_ok && !l2_ok)    perf_single_o <= perf_single_o + 32'd1;
      if (l2_ok)              perf_dual_o   <= perf_dual_o + 32'd1;
    end
  end
`endif

endmodule
